puf_bit_gen: RTL and testbench

Response-bit generator for the RO PUF. On `start` it walks a chain of ring-oscillator pairs, enables each pair for a fixed window, counts their synchronized edge ticks, compares the counts and emits one response bit per pair as a serial strobe. `bit_out`/`bit_valid` drive the 256-bit response shift register's `s_in`/`en` directly, so the register holds the full response after `done`.

---
 rtl/puf_bit_gen.sv | 148 ++++++++++++++
 tb/tb_puf_bit_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/puf_bit_gen.sv
// RO PUF response-bit generator: settles, measures and compares each RO pair in turn, one serial bit per pair.
// Optional tie counter is built when PUF_TIE_COUNT_EN is defined; otherwise tie_count is tied to 0.
module puf_bit_gen #(
    parameter int N_BITS = 256,
    parameter int SEL_W  = 8,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 16,
    parameter int WINDOW = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_a_tick,
    input  logic             ro_b_tick,
    output logic             ro_en,
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [SEL_W:0]   tie_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam int PH_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_t            state;
    logic [PH_W-1:0]   phase;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic [CNT_W-1:0]  cnt_a_nxt;
    logic [CNT_W-1:0]  cnt_b_nxt;
    logic              last_pair;
    logic              window_end;

    // The compare uses the post-increment counts so a tick in the final MEASURE cycle still counts.
    always_comb begin
        cnt_a_nxt = cnt_a;
        cnt_b_nxt = cnt_b;
        if (ro_a_tick && (cnt_a != {CNT_W{1'b1}})) cnt_a_nxt = cnt_a + 1'b1;
        if (ro_b_tick && (cnt_b != {CNT_W{1'b1}})) cnt_b_nxt = cnt_b + 1'b1;
    end

    assign last_pair  = (sel_a == SEL_W'(N_BITS - 1));
    assign window_end = (state == S_MEASURE) && (phase == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= '0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            ro_en     <= 1'b0;
            sel_a     <= '0;
            sel_b     <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SETTLE;
                        phase <= PH_W'(SETTLE - 1);
                        cnt_a <= '0;
                        cnt_b <= '0;
                        sel_a <= '0;
                        sel_b <= (N_BITS > 1) ? SEL_W'(1) : '0;
                        ro_en <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (phase == '0) begin
                        state <= S_MEASURE;
                        phase <= PH_W'(WINDOW - 1);
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                S_MEASURE: begin
                    cnt_a <= cnt_a_nxt;
                    cnt_b <= cnt_b_nxt;
                    if (phase == '0) begin
                        state     <= S_COMPARE;
                        ro_en     <= 1'b0;
                        bit_valid <= 1'b1;
                        bit_out   <= (cnt_a_nxt > cnt_b_nxt);
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                S_COMPARE: begin
                    cnt_a <= '0;
                    cnt_b <= '0;
                    if (last_pair) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_SETTLE;
                        phase <= PH_W'(SETTLE - 1);
                        sel_a <= sel_a + 1'b1;
                        sel_b <= (sel_b == SEL_W'(N_BITS - 1)) ? '0 : sel_b + 1'b1;
                        ro_en <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PUF_TIE_COUNT_EN
    logic [SEL_W:0] tie_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tie_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            tie_q <= '0;
        end else if (window_end && (cnt_a_nxt == cnt_b_nxt)) begin
            tie_q <= tie_q + 1'b1;
        end
    end

    assign tie_count = tie_q;
`else
    assign tie_count = '0;
`endif

endmodule

// File: tb/tb_puf_bit_gen.sv
// Directed bench for puf_bit_gen (N_BITS=4, SETTLE=2, WINDOW=8): driver pushes expected bits/done into queues, monitor pops and compares.
module tb_puf_bit_gen;

    localparam int N_BITS = 4;
    localparam int SEL_W  = 8;
    localparam int CNT_W  = 16;
    localparam int SETTLE = 2;
    localparam int WINDOW = 8;
    localparam int PER_BIT = SETTLE + WINDOW + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             ro_a_tick = 1'b0;
    logic             ro_b_tick = 1'b0;
    logic             ro_en;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             bit_out;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic [SEL_W:0]   tie_count;

    puf_bit_gen #(
        .N_BITS(N_BITS), .SEL_W(SEL_W), .CNT_W(CNT_W), .SETTLE(SETTLE), .WINDOW(WINDOW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ro_a_tick(ro_a_tick), .ro_b_tick(ro_b_tick),
        .ro_en(ro_en), .sel_a(sel_a), .sel_b(sel_b), .bit_out(bit_out), .bit_valid(bit_valid),
        .busy(busy), .done(done), .tie_count(tie_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: bit entries {sel_b, sel_a, bit, offset}, done entries {tie, offset}
    logic [24:0] exp_q[$];
    logic [16:0] done_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] exp_tie(input int n);
`ifdef PUF_TIE_COUNT_EN
        return 9'(n);
`else
        return 9'(n & 0);
`endif
    endfunction

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bit_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit_valid", 32'd1, 32'd0);
                end else begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    check("bit_valid_cycle", 32'(cyc - start_cyc), 32'(e[7:0]));
                    check("bit_out", 32'(bit_out), 32'(e[8]));
                    check("sel_a_at_bit", 32'(sel_a), 32'(e[16:9]));
                    check("sel_b_at_bit", 32'(sel_b), 32'(e[24:17]));
                    check("ro_en_in_compare", 32'(ro_en), 32'd0);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [16:0] d;
                    d = done_q.pop_front();
                    check("done_cycle", 32'(cyc - start_cyc), 32'(d[7:0]));
                    check("tie_count_at_done", 32'(tie_count), 32'(d[16:8]));
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ro_en"}, 32'(ro_en), 32'd0);
        check({tag, "_sel_a"}, 32'(sel_a), 32'd0);
        check({tag, "_sel_b"}, 32'(sel_b), 32'd0);
        check({tag, "_bit_out"}, 32'(bit_out), 32'd0);
        check({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_tie_count"}, 32'(tie_count), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc - 1;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic run_pair(input int p, input logic [1:0] sa, input logic [1:0] sb,
                            input logic [7:0] ma, input logic [7:0] mb,
                            input logic exp_bit, input logic start_mid);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = 8'(p);
        eb = 8'((p + 1) % N_BITS);
        exp_q.push_back({eb, ea, exp_bit, 8'(p * PER_BIT + PER_BIT)});
        check("ro_en_pair", 32'(ro_en), 32'd1);
        check("sel_a_pair", 32'(sel_a), 32'(ea));
        check("sel_b_pair", 32'(sel_b), 32'(eb));
        for (int i = 0; i < SETTLE; i++) begin
            ro_a_tick = sa[i];
            ro_b_tick = sb[i];
            step();
        end
        for (int i = 0; i < WINDOW; i++) begin
            ro_a_tick = ma[i];
            ro_b_tick = mb[i];
            start = start_mid && (i == 0);
            step();
        end
        ro_a_tick = 1'b0;
        ro_b_tick = 1'b0;
        start = 1'b0;
        step();
    endtask

    task automatic finish_run(input int ties);
        done_q.push_back({exp_tie(ties), 8'(N_BITS * PER_BIT + 1)});
        step();
        check("busy_after_done", 32'(busy), 32'd0);
        repeat (2) step();
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();
        check_all_zero("idle");

        // run 1: 8/3, 2/6, 5/5 (tie), 7/0; stray start during pair 1
        do_start();
        run_pair(0, 2'b00, 2'b00, 8'hFF, 8'h07, 1'b1, 1'b0);
        run_pair(1, 2'b00, 2'b00, 8'h03, 8'h3F, 1'b0, 1'b1);
        run_pair(2, 2'b00, 2'b00, 8'h1F, 8'h1F, 1'b0, 1'b0);
        run_pair(3, 2'b00, 2'b00, 8'h7F, 8'h00, 1'b1, 1'b0);
        finish_run(1);

        // run 2: SETTLE ticks ignored, last-cycle tick counted, two ties
        do_start();
        run_pair(0, 2'b11, 2'b00, 8'h00, 8'h01, 1'b0, 1'b0);
        run_pair(1, 2'b00, 2'b00, 8'h80, 8'h00, 1'b1, 1'b0);
        run_pair(2, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_pair(3, 2'b00, 2'b00, 8'hFF, 8'hFF, 1'b0, 1'b0);
        finish_run(2);

        // run aborted by reset during MEASURE of pair 2
        do_start();
        run_pair(0, 2'b00, 2'b00, 8'h01, 8'h00, 1'b1, 1'b0);
        run_pair(1, 2'b00, 2'b00, 8'h00, 8'h01, 1'b0, 1'b0);
        repeat (SETTLE) step();
        ro_a_tick = 1'b1;
        repeat (3) step();
        ro_a_tick = 1'b0;
        rst = 1'b1;
        step();
        check_all_zero("mid_reset");
        rst = 1'b0;
        repeat (WINDOW + 4) begin
            step();
            check("busy_after_abort", 32'(busy), 32'd0);
        end

        // run 3 after reset: restarts at pair 0
        do_start();
        run_pair(0, 2'b00, 2'b00, 8'h01, 8'h00, 1'b1, 1'b0);
        run_pair(1, 2'b00, 2'b00, 8'h07, 8'h07, 1'b0, 1'b0);
        run_pair(2, 2'b00, 2'b00, 8'h0F, 8'h03, 1'b1, 1'b0);
        run_pair(3, 2'b00, 2'b00, 8'h03, 8'h0F, 1'b0, 1'b0);
        finish_run(1);

        check("bits_outstanding", 32'(exp_q.size()), 32'd0);
        check("done_outstanding", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
